// File: rtl/sdram_write_seg_if.sv
// Bundles the request and SDRAM-side signals of the segmented burst-write engine.
// The slave modport is the engine. The master modport is its upstream and bus-side
// environment.
// The DQM pass-through pair exists only when SDRAM_WR_DQM_EN is defined.
interface sdram_write_seg_if #(
  parameter int DATA_W = 16,
  parameter int BA_W   = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 10
);
  logic                        init_end;
  logic                        wr_en;
  logic [BA_W+ROW_W+COL_W-1:0] wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic [LEN_W-1:0]            wr_burst_len;
  logic                        wr_ack;
  logic                        wr_end;
  logic                        wr_busy;
  logic [3:0]                  write_cmd;
  logic [BA_W-1:0]             write_ba;
  logic [ROW_W-1:0]            write_addr;
  logic                        wr_sdram_en;
  logic [DATA_W-1:0]           wr_sdram_data;
`ifdef SDRAM_WR_DQM_EN
  logic [DATA_W/8-1:0]         wr_dqm;
  logic [DATA_W/8-1:0]         wr_sdram_dqm;
`endif

  modport slave (
    input  init_end, wr_en, wr_addr, wr_data, wr_burst_len,
`ifdef SDRAM_WR_DQM_EN
    input  wr_dqm,
    output wr_sdram_dqm,
`endif
    output wr_ack, wr_end, wr_busy, write_cmd, write_ba, write_addr,
    output wr_sdram_en, wr_sdram_data
  );

  modport master (
    output init_end, wr_en, wr_addr, wr_data, wr_burst_len,
`ifdef SDRAM_WR_DQM_EN
    output wr_dqm,
    input  wr_sdram_dqm,
`endif
    input  wr_ack, wr_end, wr_busy, write_cmd, write_ba, write_addr,
    input  wr_sdram_en, wr_sdram_data
  );
endinterface

// File: rtl/sdram_write_seg.sv
// Parametrised SDRAM burst-write engine with automatic row-boundary splitting.
//
// A request is cut into segments that never cross the end of a row. Each segment
// runs ACTIVE, then tRCD, then WRITE and the data beats, then BURST STOP, then tWR,
// then PRECHARGE (all banks) and finally tRP. The next segment resumes at column 0
// of the following {bank,row}.
//
// Every command is registered from the current state, so it reaches the bus one
// cycle after that state. wr_ack, wr_end and wr_busy are registered so that they
// are high during the state they describe.
//
// The timing parameters TRCD_CLK, TWR_CLK and TRP_CLK must be at least 1.
//
// Optional feature: defining SDRAM_WR_DQM_EN adds the wr_dqm to wr_sdram_dqm
// byte-mask path.
module sdram_write_seg #(
  parameter int DATA_W   = 16,
  parameter int BA_W     = 2,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 9,
  parameter int LEN_W    = 10,
  parameter int TRCD_CLK = 2,
  parameter int TWR_CLK  = 2,
  parameter int TRP_CLK  = 2
) (
  input logic              sys_clk,
  input logic              sys_rst,
  sdram_write_seg_if.slave wr
);

  localparam int BR_W = BA_W + ROW_W;
  // Shared width for the wait counter and the segment arithmetic.
  localparam int W0 = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;
  localparam int W  = (W0 > 8) ? W0 : 8;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  // A10 high selects all banks for PRECHARGE.
  localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1) << 10;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_WRITE, S_DATA, S_TWR, S_PRE, S_TRP, S_END
  } state_t;

  state_t           state;
  logic [W-1:0]     cnt;
  logic [W-1:0]     seg_q;
  logic [LEN_W-1:0] remaining;
  logic [BR_W-1:0]  br;
  logic [COL_W-1:0] col;

  logic [3:0]       cmd_q;
  logic [BA_W-1:0]  ba_q;
  logic [ROW_W-1:0] addr_q;
  logic             ack_q;
  logic             end_q;
  logic             busy_q;
  logic             en_q;

  logic [W-1:0]     room;
  logic [W-1:0]     rem_ext;
  logic [W-1:0]     seg_calc;
  logic [ROW_W-1:0] col_addr;

  // Segment length: the smaller of the words still owed and the words left in the row.
  always_comb begin
    // NOTE: every signal gets a value on every path before it is used. A variable
    // left unassigned on some path of a combinational block becomes a latch.
    // Combinational blocks use blocking '=' and clocked blocks use '<='.
    room        = W'({1'b1, {COL_W{1'b0}}}) - W'(col);
    rem_ext     = W'(remaining);
    seg_calc    = (rem_ext < room) ? rem_ext : room;
    col_addr    = ROW_W'(col);
    col_addr[10] = 1'b0;
  end

  // Sequencer together with the registered command, handshake and DQ-enable outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      seg_q     <= '0;
      remaining <= '0;
      br        <= '0;
      col       <= '0;
      cmd_q     <= CMD_NOP;
      ba_q      <= '1;
      addr_q    <= '1;
      ack_q     <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= '1;
      addr_q <= '1;
      ack_q  <= 1'b0;
      end_q  <= 1'b0;
      en_q   <= ack_q;

      case (state)
        S_IDLE: begin
          if (wr.wr_en && wr.init_end && (wr.wr_burst_len != '0)) begin
            br        <= wr.wr_addr[BA_W+ROW_W+COL_W-1 -: BR_W];
            col       <= wr.wr_addr[COL_W-1:0];
            remaining <= wr.wr_burst_len;
            busy_q    <= 1'b1;
            state     <= S_ACT;
          end
        end
        S_ACT: begin
          cmd_q  <= CMD_ACT;
          ba_q   <= br[BR_W-1 -: BA_W];
          addr_q <= br[ROW_W-1:0];
          cnt    <= '0;
          state  <= S_TRCD;
        end
        S_TRCD: begin
          if (cnt == W'(TRCD_CLK - 1)) begin
            ack_q <= 1'b1;
            state <= S_WRITE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        S_WRITE: begin
          cmd_q     <= CMD_WRITE;
          ba_q      <= br[BR_W-1 -: BA_W];
          addr_q    <= col_addr;
          seg_q     <= seg_calc;
          remaining <= remaining - LEN_W'(seg_calc);
          ack_q     <= (seg_calc > W'(1));
          cnt       <= '0;
          state     <= S_DATA;
        end
        S_DATA: begin
          if (cnt == seg_q - W'(1)) begin
            cmd_q <= CMD_BSTOP;
            cnt   <= '0;
            state <= S_TWR;
          end else begin
            cnt   <= cnt + W'(1);
            ack_q <= (cnt + W'(2) < seg_q);
          end
        end
        S_TWR: begin
          if (cnt == W'(TWR_CLK - 1)) begin
            state <= S_PRE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        S_PRE: begin
          cmd_q  <= CMD_PRE;
          ba_q   <= br[BR_W-1 -: BA_W];
          addr_q <= PRE_ADDR;
          cnt    <= '0;
          state  <= S_TRP;
        end
        S_TRP: begin
          if (cnt == W'(TRP_CLK - 1)) begin
            if (remaining == '0) begin
              end_q <= 1'b1;
              state <= S_END;
            end else begin
              br    <= br + BR_W'(1);
              col   <= '0;
              state <= S_ACT;
            end
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        S_END: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wr.wr_ack        = ack_q;
  assign wr.wr_end        = end_q;
  assign wr.wr_busy       = busy_q;
  assign wr.write_cmd     = cmd_q;
  assign wr.write_ba      = ba_q;
  assign wr.write_addr    = addr_q;
  assign wr.wr_sdram_en   = en_q;
  assign wr.wr_sdram_data = en_q ? wr.wr_data : '0;
`ifdef SDRAM_WR_DQM_EN
  assign wr.wr_sdram_dqm  = en_q ? wr.wr_dqm : '1;
`endif

endmodule

// File: doc/sdram_write_seg.md
Name: sdram_write_seg

Overview:
- Parametrised SDRAM burst-write engine, successor to the fixed 16-bit single-row write block.
- Sits between the arbiter (grants wr_en after init_end) and the SDRAM command/DQ mux.
- Generalises data, bank, row and column widths and all timing waits.
- Adds a tWR wait before precharge and automatic row-boundary splitting: a burst crossing the end of a row is terminated, precharged, and resumed at column 0 of the next row, with no upstream involvement.

Parameters:
- DATA_W, 16, DQ width.
- BA_W, 2, bank address width.
- ROW_W, 13, row address width; must be at least 11.
- COL_W, 9, column address width; a row holds 2^COL_W words.
- LEN_W, 10, wr_burst_len width.
- TRCD_CLK, 2, NOP cycles between ACTIVE and WRITE.
- TWR_CLK, 2, NOP cycles between BURST STOP and PRECHARGE.
- TRP_CLK, 2, NOP cycles after PRECHARGE.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- init_end  in  1  SDRAM initialisation done.
- wr_en  in  1  write request.
- wr_addr  in  BA_W+ROW_W+COL_W  start address {bank,row,col}.
- wr_data  in  DATA_W  write word, valid the cycle after each wr_ack.
- wr_burst_len  in  LEN_W  total words to write.
- wr_ack  out  1  word-consume strobe to upstream.
- wr_end  out  1  one-cycle pulse when the whole request completes.
- wr_busy  out  1  high from accept until wr_end inclusive.
- write_cmd  out  4  {cs_n,ras_n,cas_n,we_n}.
- write_ba  out  BA_W  bank address.
- write_addr  out  ROW_W  SDRAM address bus.
- wr_sdram_en  out  1  DQ output enable.
- wr_sdram_data  out  DATA_W  DQ out.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high (sys_rst).
- Reset values: write_cmd=NOP; write_ba and write_addr all ones; wr_ack, wr_end, wr_busy, wr_sdram_en = 0; wr_sdram_data = 0; state=IDLE.
- A reset asserted mid-burst takes effect at the next edge with the same values. No BSTOP or PRECHARGE is issued.
- Command encodings: NOP 0111, ACTIVE 0011, WRITE 0100, BSTOP 0110, PRECHARGE 0010.
- All command outputs are registered from the current state, so each command appears one cycle after its state.
- Accept: in IDLE, when wr_en=1, init_end=1 and wr_burst_len!=0, latch address and length and go to ACT.
  - wr_burst_len=0 is ignored.
  - wr_en while not IDLE is ignored.
- Segment length: seg = min(remaining, 2^COL_W - col).
- States:
  - IDLE: waits for accept.
  - ACT: 1 cycle. ACTIVE with ba/row.
  - TRCD: TRCD_CLK cycles.
  - WRITE: 1 cycle. WRITE with ba and zero-extended col, A10=0.
  - DATA: seg cycles. BSTOP is loaded on the last DATA cycle.
  - TWR: TWR_CLK cycles.
  - PRE: 1 cycle. PRECHARGE with A10=1 (all banks), other address bits 0.
  - TRP: TRP_CLK cycles. Then go to END if remaining==0, else to ACT with {ba,row} incremented by 1 modulo 2^(BA_W+ROW_W) and col=0.
  - END: 1 cycle. wr_end=1, then IDLE.
- wr_ack timing: high in the WRITE cycle and the first seg-1 DATA cycles, so exactly seg acks per segment and exactly wr_burst_len acks per request.
- Data path:
  - wr_sdram_en <= wr_ack (registered).
  - wr_sdram_data = wr_sdram_en ? wr_data : 0.
  - The first data word coincides with the WRITE command on the bus.
- Counter: a single wait counter is cleared on entry to every timed state. Remaining-word count is decremented by seg at WRITE.
- Address wrap: {bank,row} wraps from all ones to 0.

Optional Feature:
- SDRAM_WR_DQM_EN defined: adds input wr_dqm [DATA_W/8] and output wr_sdram_dqm [DATA_W/8].
  - wr_dqm is sampled alongside wr_data.
  - wr_sdram_dqm = wr_sdram_en ? wr_dqm : all ones.
- Undefined: no DQM ports are present; byte masking is handled outside the block.

Test Plan:
- Single segment: len=10, addr {1,5,0}, TRCD_CLK=2 -> ACTIVE(ba1,row5); 2 NOPs; WRITE col0; 10 consecutive acks; BSTOP; 2 NOPs; PRECHARGE addr 0x400; wr_end once.
- Row split: len=8, bank 1, row 5, col 508 -> 4 acks then BSTOP/PRE; ACTIVE row 6; WRITE col0; 4 acks; total 8 acks, 2 PRECHARGEs, 1 wr_end.
- Address wrap: bank 3, row 8191, col 510, len 4 -> second ACTIVE at ba0 row0; 2+2 acks.
- Gating: wr_en=1 with init_end=0 for 20 cycles, then len=0 with init_end=1 -> no command other than NOP, wr_busy stays 0.
- Reset mid-DATA (5th ack) -> next cycle NOP, ba=11, addr all ones, wr_sdram_en=0, IDLE. A new request afterwards completes normally.
- With SDRAM_WR_DQM_EN, wr_dqm=01 on word 3 -> wr_sdram_dqm=01 in the same cycle as data word 3, and 11 outside the burst.
